// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: synchronises and glitch-filters both encoder channels,
// tracks the Gray position and emits step/direction pulses plus illegal-transition errors.
module quad_step_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enable,
    input  logic                 err_clr,
    output logic                 step,
    output logic                 up,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           pos
);

    localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_P00,
        ST_P01,
        ST_P11,
        ST_P10
    } state_t;

    logic [1:0]           w_raw;
    logic [1:0]           w_filt;
    logic [1:0]           w_cur;
    state_t               r_state;
    logic                 r_step;
    logic                 r_up;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [1:0]           r_pos;

    assign w_raw = {enc_a, enc_b};

    // Per channel: synchroniser chain, then a stability filter on the synchronised bit.
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] r_sync;
        logic                   r_prev;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_filt;
        logic                   w_sync;
        logic [CNT_W-1:0]       w_run;

        assign w_sync = r_sync[SYNC_STAGES-1];
        // Length of the current stable run including this cycle.
        assign w_run  = (w_sync != r_prev) ? CNT_W'(1) : r_cnt + CNT_W'(1);
        assign w_filt[ch] = r_filt;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_sync <= '0;
                r_prev <= 1'b0;
                r_cnt  <= '0;
                r_filt <= 1'b0;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[ch]};
                r_prev <= w_sync;
                if (w_sync == r_filt) begin
                    r_cnt <= '0;
                end else if (w_run >= CNT_W'(FILT_LEN)) begin
                    r_filt <= w_sync;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= w_run;
                end
            end
        end
    end

    function automatic state_t pos_to_state(input logic [1:0] p);
        state_t s;
        case (p)
            2'b00:   s = ST_P00;
            2'b01:   s = ST_P01;
            2'b11:   s = ST_P11;
            default: s = ST_P10;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] state_to_pos(input state_t s);
        logic [1:0] p;
        case (s)
            ST_P01:  p = 2'b01;
            ST_P11:  p = 2'b11;
            ST_P10:  p = 2'b10;
            default: p = 2'b00;
        endcase
        return p;
    endfunction

    // Forward Gray successor: 00->01->11->10->00.
    function automatic logic [1:0] fwd_of(input logic [1:0] p);
        return {p[0], ~p[1]};
    endfunction

    // Reverse Gray successor: 00->10->11->01->00.
    function automatic logic [1:0] rev_of(input logic [1:0] p);
        return {~p[0], p[1]};
    endfunction

    assign w_cur = state_to_pos(r_state);

    // Position tracker with registered step/direction/error outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_INIT;
            r_step      <= 1'b0;
            r_up        <= 1'b1;
            r_err       <= 1'b0;
            r_err_count <= '0;
            r_pos       <= 2'b00;
        end else begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
            if (err_clr) begin
                r_err_count <= '0;
            end
            if (r_state == ST_INIT) begin
                r_state <= pos_to_state(w_filt);
                r_pos   <= w_filt;
            end else if (w_filt != w_cur) begin
                r_state <= pos_to_state(w_filt);
                r_pos   <= w_filt;
                if (w_filt == fwd_of(w_cur)) begin
                    if (enable) begin
                        r_step <= 1'b1;
                        r_up   <= 1'b1;
                    end
                end else if (w_filt == rev_of(w_cur)) begin
                    if (enable) begin
                        r_step <= 1'b1;
                        r_up   <= 1'b0;
                    end
                end else if (enable) begin
                    // Both channels moved at once: direction is unknowable.
                    r_err <= 1'b1;
                    if (!err_clr && (r_err_count != ERR_MAX)) begin
                        r_err_count <= r_err_count + ERR_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign step      = r_step;
    assign up        = r_up;
    assign err       = r_err;
    assign err_count = r_err_count;
    assign pos       = r_pos;

endmodule
